// File: rtl/read_fmps_test_link_if.sv
// AXI-Stream receive channel for FMPS test-link packets.
// The master drives the beat; the slave answers with a registered tready.
interface read_fmps_test_link_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/read_fmps_test_link.sv
// Two-beat FMPS test packet receiver: validates header/data words, tracks per-FA-cycle
// reception mask and good count, and keeps saturating header/data error counters.
module read_fmps_test_link #(
    parameter int          INDEX_WIDTH   = 5,
    parameter logic [15:0] HEADER_MAGIC  = 16'hB6CF,
    parameter logic [15:0] DATA_MAGIC    = 16'hCACA,
    parameter int          ERR_CNT_WIDTH = 16
) (
    input  logic                          auroraUserClk,
    input  logic                          auroraResetN,
    input  logic                          auroraFAstrobe,
    read_fmps_test_link_if.slave          FMPS_TEST_AXI_STREAM_RX,
    output logic                          packetStrobe,
    output logic [INDEX_WIDTH-1:0]        packetIndex,
    output logic [31:0]                   packetData,
    output logic [(2**INDEX_WIDTH)-1:0]   rxMask,
    output logic [7:0]                    goodCount,
    output logic                          errorStrobe,
    output logic [2:0]                    errorCode,
    output logic [ERR_CNT_WIDTH-1:0]      headerErrCount,
    output logic [ERR_CNT_WIDTH-1:0]      dataErrCount
);
    typedef enum logic [1:0] {S_HEADER, S_DATA, S_DRAIN} state_t;

    state_t                        r_state, w_next;
    logic   [INDEX_WIDTH-1:0]      r_index;
    logic   [7:0]                  r_exp_cycle;
    logic                          r_tready;
    logic                          r_pkt_strobe;
    logic   [INDEX_WIDTH-1:0]      r_pkt_index;
    logic   [31:0]                 r_pkt_data;
    logic   [(2**INDEX_WIDTH)-1:0] r_rx_mask;
    logic   [7:0]                  r_good_cnt;
    logic                          r_err_strobe;
    logic   [2:0]                  r_err_code;
    logic   [ERR_CNT_WIDTH-1:0]    r_hdr_err_cnt;
    logic   [ERR_CNT_WIDTH-1:0]    r_dat_err_cnt;

    logic        w_xfer;
    logic [31:0] w_data;
    logic        w_last;
    logic [2:0]  w_code;
    logic        w_good;
    logic        w_latch;
    logic        w_hdr_err;
    logic        w_dat_err;

    assign w_data    = FMPS_TEST_AXI_STREAM_RX.tdata;
    assign w_last    = FMPS_TEST_AXI_STREAM_RX.tlast;
    assign w_xfer    = FMPS_TEST_AXI_STREAM_RX.tvalid && r_tready;
    assign w_hdr_err = (w_code != 3'd0) && (w_code <= 3'd3);
    assign w_dat_err = (w_code >= 3'd4);

    always_ff @(posedge auroraUserClk) begin
        if (!auroraResetN) r_state <= S_HEADER;
        else               r_state <= w_next;
    end

    // Error code 0 means "no error"; data checks use expectedCycle before any FA increment.
    always_comb begin
        w_next  = r_state;
        w_code  = 3'd0;
        w_good  = 1'b0;
        w_latch = 1'b0;
        if (w_xfer) begin
            case (r_state)
                S_HEADER: begin
                    if (w_data[31:16] != HEADER_MAGIC) begin
                        w_code = 3'd1;
                        if (!w_last) w_next = S_DRAIN;
                    end else if (w_last) begin
                        w_code = 3'd2;
                    end else begin
                        w_latch = 1'b1;
                        w_next  = S_DATA;
                    end
                end
                S_DATA: begin
                    w_next = S_HEADER;
                    if (!w_last) begin
                        w_code = 3'd3;
                        w_next = S_DRAIN;
                    end else if (|w_data[31:29])                          w_code = 3'd4;
                    else if (w_data[24 +: INDEX_WIDTH] != r_index)         w_code = 3'd5;
                    else if (w_data[23:8] != DATA_MAGIC)                   w_code = 3'd6;
                    else if (w_data[7:0] != r_exp_cycle)                   w_code = 3'd7;
                    else                                                   w_good = 1'b1;
                end
                S_DRAIN: begin
                    if (w_last) w_next = S_HEADER;
                end
                default: w_next = S_HEADER;
            endcase
        end
    end

    always_ff @(posedge auroraUserClk) begin
        if (!auroraResetN) begin
            r_index       <= '0;
            r_exp_cycle   <= '0;
            r_tready      <= 1'b0;
            r_pkt_strobe  <= 1'b0;
            r_pkt_index   <= '0;
            r_pkt_data    <= '0;
            r_rx_mask     <= '0;
            r_good_cnt    <= '0;
            r_err_strobe  <= 1'b0;
            r_err_code    <= '0;
            r_hdr_err_cnt <= '0;
            r_dat_err_cnt <= '0;
        end else begin
            r_tready     <= 1'b1;
            r_pkt_strobe <= w_good;
            r_err_strobe <= (w_code != 3'd0);
            if (w_code != 3'd0) r_err_code <= w_code;
            if (w_latch) r_index <= w_data[10 +: INDEX_WIDTH];
            if (w_good) begin
                r_pkt_index <= r_index;
                r_pkt_data  <= w_data;
            end
            if (w_hdr_err && (r_hdr_err_cnt != '1)) r_hdr_err_cnt <= r_hdr_err_cnt + 1'b1;
            if (w_dat_err && (r_dat_err_cnt != '1)) r_dat_err_cnt <= r_dat_err_cnt + 1'b1;
            // FA clear takes priority over a good packet decided in the same cycle.
            if (auroraFAstrobe) begin
                r_exp_cycle <= r_exp_cycle + 8'd1;
                r_rx_mask   <= '0;
                r_good_cnt  <= '0;
            end else if (w_good) begin
                r_rx_mask[r_index] <= 1'b1;
                if (r_good_cnt != 8'hFF) r_good_cnt <= r_good_cnt + 8'd1;
            end
        end
    end

    assign FMPS_TEST_AXI_STREAM_RX.tready = r_tready;
    assign packetStrobe   = r_pkt_strobe;
    assign packetIndex    = r_pkt_index;
    assign packetData     = r_pkt_data;
    assign rxMask         = r_rx_mask;
    assign goodCount      = r_good_cnt;
    assign errorStrobe    = r_err_strobe;
    assign errorCode      = r_err_code;
    assign headerErrCount = r_hdr_err_cnt;
    assign dataErrCount   = r_dat_err_cnt;
endmodule

// File: tb/tb_read_fmps_test_link.sv
// Bench for read_fmps_test_link: directed scenarios plus random packets, checked every
// cycle against a packet-position reference model.
module tb_read_fmps_test_link;
    localparam int          IW = 5;
    localparam logic [15:0] HM = 16'hB6CF;
    localparam logic [15:0] DM = 16'hCACA;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic fa = 1'b0;
    always #5 clk = ~clk;

    read_fmps_test_link_if axi();

    logic           packetStrobe, errorStrobe;
    logic [IW-1:0]  packetIndex;
    logic [31:0]    packetData;
    logic [31:0]    rxMask;
    logic [7:0]     goodCount;
    logic [2:0]     errorCode;
    logic [15:0]    headerErrCount, dataErrCount;

    read_fmps_test_link dut (
        .auroraUserClk(clk), .auroraResetN(rstn), .auroraFAstrobe(fa),
        .FMPS_TEST_AXI_STREAM_RX(axi.slave),
        .packetStrobe(packetStrobe), .packetIndex(packetIndex), .packetData(packetData),
        .rxMask(rxMask), .goodCount(goodCount), .errorStrobe(errorStrobe),
        .errorCode(errorCode), .headerErrCount(headerErrCount), .dataErrCount(dataErrCount)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: tracks the beats of the current packet by position.
    logic [31:0] m_pkt[$];
    bit          m_drop;
    bit          m_rdy, m_pstb, m_estb;
    logic [7:0]  m_exp, m_good;
    logic [31:0] m_mask, m_pdata;
    logic [IW-1:0] m_pidx;
    logic [2:0]  m_ecode;
    logic [15:0] m_herr, m_derr;

    task automatic model_step(input bit xf, input logic [31:0] d, input bit l, input bit f);
        int code;
        bit good;
        logic [IW-1:0] hidx;
        m_pstb = 0;
        m_estb = 0;
        if (!rstn) begin
            m_pkt.delete(); m_drop = 0; m_rdy = 0;
            m_exp = 0; m_good = 0; m_mask = 0; m_pdata = 0; m_pidx = 0;
            m_ecode = 0; m_herr = 0; m_derr = 0;
            return;
        end
        m_rdy = 1;
        code = 0;
        good = 0;
        if (xf) begin
            m_pkt.push_back(d);
            if (!m_drop) begin
                if (m_pkt.size() == 1) begin
                    if (d[31:16] != HM) code = 1;
                    else if (l)         code = 2;
                end else begin
                    hidx = m_pkt[0][10 +: IW];
                    if (!l)                      code = 3;
                    else if (d[31:29] != 3'b000) code = 4;
                    else if (d[28:24] != hidx)   code = 5;
                    else if (d[23:8] != DM)      code = 6;
                    else if (d[7:0] != m_exp)    code = 7;
                    else                         good = 1;
                end
                if (code != 0 && !l) m_drop = 1;
            end
            if (l) begin
                m_pkt.delete();
                m_drop = 0;
            end
        end
        if (code != 0) begin
            m_estb = 1;
            m_ecode = code[2:0];
            if (code <= 3) begin if (m_herr != 16'hFFFF) m_herr++; end
            else           begin if (m_derr != 16'hFFFF) m_derr++; end
        end
        if (good) begin
            m_pstb = 1;
            m_pidx = d[28:24];
            m_pdata = d;
        end
        if (f) begin
            m_exp = m_exp + 8'd1;
            m_mask = 0;
            m_good = 0;
        end else if (good) begin
            m_mask[d[28:24]] = 1'b1;
            if (m_good != 8'hFF) m_good++;
        end
    endtask

    task automatic compare_all();
        chk("tready", axi.tready, m_rdy);
        chk("packetStrobe", packetStrobe, m_pstb);
        chk("errorStrobe", errorStrobe, m_estb);
        chk("errorCode", errorCode, m_ecode);
        chk("packetIndex", packetIndex, m_pidx);
        chk("packetData", packetData, m_pdata);
        chk("rxMask", rxMask, m_mask);
        chk("goodCount", goodCount, m_good);
        chk("headerErrCount", headerErrCount, m_herr);
        chk("dataErrCount", dataErrCount, m_derr);
    endtask

    task automatic cyc(input bit v, input logic [31:0] d, input bit l, input bit f, output bit xf);
        @(negedge clk);
        axi.tvalid = v;
        axi.tdata  = d;
        axi.tlast  = l;
        fa = f;
        xf = v && axi.tready;
        @(posedge clk);
        model_step(xf, d, l, f);
        #1 compare_all();
    endtask

    task automatic idle(input int n);
        bit xf;
        for (int i = 0; i < n; i++) cyc(0, 32'h0, 0, 0, xf);
    endtask

    task automatic fa_pulse();
        bit xf;
        cyc(0, 32'h0, 0, 1, xf);
    endtask

    // Hold the beat until it is accepted; randomly overlap FA strobes when rfa is set.
    task automatic send(input logic [31:0] d, input bit l, input bit rfa = 0);
        bit xf;
        xf = 0;
        for (int k = 0; k < 20 && !xf; k++) cyc(1, d, l, rfa && ($urandom_range(0, 7) == 0), xf);
        if (!xf) chk("xfer_timeout", 0, 1);
        if (rfa) idle($urandom_range(0, 2));
    endtask

    task automatic reset_dut();
        rstn = 0;
        idle(2);
        rstn = 1;
        idle(1);
    endtask

    function automatic logic [31:0] hdr(input int idx);
        return {HM, 16'h0} | (32'(idx) << 10);
    endfunction

    function automatic logic [31:0] dat(input int idx, input logic [7:0] cyc8);
        return {3'b000, 5'(idx), DM, cyc8};
    endfunction

    initial begin
        axi.tvalid = 0; axi.tdata = 0; axi.tlast = 0;
        m_pkt.delete(); m_drop = 0;
        rstn = 0;
        idle(2);
        chk("reset_tready", axi.tready, 0);
        chk("reset_rxMask", rxMask, 0);
        rstn = 1;
        idle(1);

        // Basic good packet after one FA strobe
        fa_pulse();
        send(32'hB6CF0400, 0);
        send(32'h01CACA01, 1);
        chk("good_strobe", packetStrobe, 1);
        chk("good_index", packetIndex, 1);
        chk("good_data", packetData, 32'h01CACA01);
        chk("good_mask", rxMask, 32'h2);
        chk("good_count", goodCount, 1);

        // Bad header magic, drained data, then a good packet
        send(32'h12340000, 0);
        chk("badhdr_code", errorCode, 1);
        chk("badhdr_cnt", headerErrCount, 1);
        send(32'h00CACA01, 1);
        chk("drain_quiet", errorStrobe, 0);
        send(hdr(0), 0);
        send(dat(0, 8'h01), 1);
        chk("after_drain_good", packetStrobe, 1);

        // Cycle-byte mismatch
        send(hdr(0), 0);
        send(32'h00CACA02, 1);
        chk("cycle_code", errorCode, 7);
        chk("cycle_derr", dataErrCount, 1);
        chk("cycle_mask", rxMask, 32'h3);

        // Long packet
        send(hdr(2), 0);
        send(dat(2, 8'h01), 0);
        chk("long_code", errorCode, 3);
        send(32'h0, 1);
        chk("long_tail_quiet", errorStrobe, 0);
        send(hdr(2), 0);
        send(dat(2, 8'h01), 1);
        chk("long_then_good", packetStrobe, 1);

        // Eight good packets with gaps, then FA clears
        reset_dut();
        fa_pulse();
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 3));
            send(hdr(i), 0);
            idle($urandom_range(0, 3));
            send(dat(i, 8'h01), 1);
        end
        chk("eight_mask", rxMask, 32'hFF);
        chk("eight_count", goodCount, 8);
        fa_pulse();
        chk("fa_clear_mask", rxMask, 0);
        chk("fa_clear_count", goodCount, 0);
        send(hdr(9), 0);
        send(dat(9, 8'h02), 1);
        chk("exp_cycle_2", packetStrobe, 1);

        // Reset mid-packet: next beat is a header
        reset_dut();
        send(32'hB6CF0400, 0);
        reset_dut();
        send(32'h01CACA01, 1);
        chk("midrst_code", errorCode, 1);
        chk("midrst_herr", headerErrCount, 1);

        // Random packets with random FA overlap
        for (int it = 0; it < 300; it++) begin
            int kind, idx;
            logic [31:0] d;
            kind = $urandom_range(0, 7);
            idx = $urandom_range(0, 31);
            case (kind)
                0, 1, 2, 3: begin
                    send(hdr(idx), 0, 1);
                    send(dat(idx, m_exp), 1, 1);
                end
                4: send(hdr(idx) ^ 32'h00010000, 1'($urandom_range(0, 1)), 1);
                5: send(hdr(idx), 1, 1);
                6: begin
                    send(hdr(idx), 0, 1);
                    send(dat(idx, m_exp), 0, 1);
                    for (int j = 0; j < $urandom_range(0, 2); j++) send($urandom, 0, 1);
                    send($urandom, 1, 1);
                end
                default: begin
                    d = dat(idx, m_exp);
                    d[$urandom_range(0, 31)] ^= 1'b1;
                    send(hdr(idx), 0, 1);
                    send(d, 1, 1);
                end
            endcase
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
